// File: rtl/async_rx_bridge.sv
// async_rx_bridge: receives 4-phase return-to-zero bundled-data tokens from an
// asynchronous C-element pipeline, synchronizes the request into clk, and
// queues each word in a first-word fall-through FIFO.
module async_rx_bridge #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_req,
  input  logic [WIDTH-1:0]           a_data,
  output logic                       a_ack,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [FW-1:0]           flush_q, flush_d;
  logic                    ack_q, ack_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [WIDTH-1:0]        mem_d [DEPTH];

  logic req_s;
  logic req_hs;
  logic flushed;
  logic push;
  logic pop;

  // The final synchronizer flop output is req_s. The handshake FSM samples the
  // value entering that final flop, so the FSM state register and the final
  // sync flop capture the same resolved value on the same edge; this puts the
  // write SYNC_STAGES edges after a_req rises.
  assign req_s   = sync_q[SYNC_STAGES-1];
  assign req_hs  = sync_q[SYNC_STAGES-2];
  // Synchronizer flops reset to 0, so a low value is only trusted once the
  // chain has been refilled from a_req after reset.
  assign flushed = (flush_q == FW'(SYNC_STAGES));

  // Synchronizer shift and post-reset flush counter.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], a_req};
    flush_d = flush_q;
    if (state_q == RESYNC && !flushed) begin
      flush_d = flush_q + FW'(1);
    end
  end

  // Handshake FSM next state, registered acknowledge and FIFO push request.
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      RESYNC: begin
        // Leave only once the whole chain shows the request low.
        if (flushed && !req_hs && !req_s) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        // Full test uses the pre-edge count, so a pop at full cannot admit a
        // push on the same edge.
        if (req_hs && (count_q < CW'(DEPTH))) begin
          push    = 1'b1;
          ack_d   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (req_hs) begin
          ack_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = RESYNC;
    endcase
  end

  // FIFO pointer, occupancy and storage update.
  always_comb begin
    pop      = out_ready && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = a_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RESYNC;
      sync_q   <= '0;
      flush_q  <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      flush_q  <= flush_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign a_ack     = ack_q;
  assign count     = count_q;
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_async_rx_bridge.sv
// Directed bench for async_rx_bridge (WIDTH=8, DEPTH=4, SYNC_STAGES=2).
module tb_async_rx_bridge;

  logic       clk;
  logic       rst;
  logic       a_req;
  logic [7:0] a_data;
  logic       a_ack;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  async_rx_bridge #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_data   (a_data),
    .a_ack    (a_ack),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full 4-phase handshake for one token, bounded waits on both ack edges.
  task automatic send(input logic [7:0] d);
    a_data = d;
    a_req  = 1'b1;
    for (int i = 0; i < 20 && !a_ack; i++) tick(1);
    chk("send_ack_rise", a_ack, 1);
    a_req = 1'b0;
    for (int i = 0; i < 20 && a_ack; i++) tick(1);
    chk("send_ack_fall", a_ack, 0);
  endtask

  // Check head word then pop it with one edge of out_ready.
  task automatic pop_chk(input string tag, input logic [7:0] d);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  logic [7:0] got [12];
  int         ngot;
  int         max_cnt;

  initial begin
    rst = 1'b1; a_req = 1'b0; a_data = '0; out_ready = 1'b0;
    tick(2);
    chk("rst_ack", a_ack, 0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    rst = 1'b0;
    tick(4);

    // Single token: ack and data appear two edges after a_req rises.
    a_data = 8'hA5; a_req = 1'b1;
    tick(1);
    chk("t1_ack_e1", a_ack, 0);
    tick(1);
    chk("t1_ack_e2", a_ack, 1);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hA5);
    chk("t1_count", count, 1);
    a_req = 1'b0;
    tick(1);
    chk("t1_ack_hold", a_ack, 1);
    tick(1);
    chk("t1_ack_drop", a_ack, 0);
    tick(3);
    chk("t1_no_second_write", count, 1);
    pop_chk("t1_pop", 8'hA5);
    chk("t1_empty", count, 0);

    // Fill to DEPTH and hold off the fifth request.
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("fill_count4", count, 4);
    a_data = 8'h05; a_req = 1'b1;
    tick(5);
    chk("fill_bp_ack", a_ack, 0);
    chk("fill_bp_count", count, 4);
    chk("fill_head", out_data, 8'h01);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("fill_pop_no_push_ack", a_ack, 0);
    chk("fill_pop_count", count, 3);
    tick(1);
    chk("fill_5th_ack", a_ack, 1);
    chk("fill_5th_count", count, 4);
    a_req = 1'b0;
    tick(2);
    chk("fill_5th_ack_drop", a_ack, 0);
    pop_chk("fill_o2", 8'h02);
    pop_chk("fill_o3", 8'h03);
    pop_chk("fill_o4", 8'h04);
    pop_chk("fill_o5", 8'h05);
    chk("fill_drained", count, 0);

    // Push and pop on the same edge.
    send(8'h31);
    send(8'h32);
    chk("pp_count2", count, 2);
    a_data = 8'h33; a_req = 1'b1;
    tick(1);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("pp_ack", a_ack, 1);
    chk("pp_count", count, 2);
    chk("pp_head", out_data, 8'h32);
    a_req = 1'b0;
    tick(2);
    pop_chk("pp_o32", 8'h32);
    pop_chk("pp_o33", 8'h33);
    chk("pp_drained", count, 0);

    // Wrap: stream 12 tokens while out_ready toggles every cycle.
    ngot = 0; max_cnt = 0;
    fork
      begin
        for (int i = 0; i < 12; i++) send(8'h10 + 8'(i));
      end
      begin
        for (int c = 0; c < 800 && ngot < 12; c++) begin
          @(negedge clk);
          out_ready = ~out_ready;
          if (int'(count) > max_cnt) max_cnt = int'(count);
          if (out_valid && out_ready) begin
            got[ngot] = out_data;
            ngot++;
          end
        end
      end
    join
    tick(1);
    out_ready = 1'b0;
    chk("wrap_received", ngot, 12);
    chk("wrap_max_count_le4", (max_cnt <= 4), 1);
    for (int i = 0; i < 12; i++) chk($sformatf("wrap_word%0d", i), got[i], 8'h10 + 8'(i));
    chk("wrap_drained", count, 0);

    // Reset in HOLD with three words queued.
    send(8'h41);
    send(8'h42);
    a_data = 8'h43; a_req = 1'b1;
    tick(2);
    chk("rmid_hold_ack", a_ack, 1);
    chk("rmid_count3", count, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rmid_async_ack", a_ack, 0);
    chk("rmid_async_count", count, 0);
    chk("rmid_async_valid", out_valid, 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("rmid_no_capture_ack", a_ack, 0);
    chk("rmid_no_capture_count", count, 0);
    a_req = 1'b0;
    tick(4);
    chk("rmid_still_empty", count, 0);
    a_data = 8'h55; a_req = 1'b1;
    tick(2);
    chk("rmid_new_ack", a_ack, 1);
    chk("rmid_new_count", count, 1);
    chk("rmid_new_data", out_data, 8'h55);
    a_req = 1'b0;
    tick(4);
    chk("rmid_one_write", count, 1);
    pop_chk("rmid_pop", 8'h55);

    // Empty pop has no effect.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("empty_count", count, 0);
      chk("empty_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_rx_bridge.md
ASYNC_RX_BRIDGE -- requirements
Module: async_rx_bridge

Interface
REQ-001 Parameter WIDTH, default 8, width of bundled data word.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two, >= 2.
REQ-003 Parameter SYNC_STAGES, default 2, flops in the a_req synchronizer; SHALL be >= 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 a_req  input  1  4-phase return-to-zero request from upstream C-element pipeline stage; asynchronous to clk.
REQ-007 a_data  input  WIDTH  bundled data; sender holds it stable from a_req rise until a_ack rise.
REQ-008 a_ack  output  1  4-phase acknowledge back to upstream C-element; registered.
REQ-009 out_valid  output  1  FIFO head holds a word.
REQ-010 out_data  output  WIDTH  FIFO head word (first-word fall-through).
REQ-011 out_ready  input  1  consumer accepts head when out_valid=1.
REQ-012 count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Function
REQ-013 a_req SHALL pass through SYNC_STAGES flops; last flop output is req_s; a_data SHALL NOT be synchronized.
REQ-014 FSM states: RESYNC, IDLE, HOLD; encoding free.
REQ-015 RESYNC: a_ack=0; when req_s=0 -> IDLE next edge, else stay.
REQ-016 IDLE: a_ack=0; when req_s=1 and count<DEPTH at that edge: write a_data into FIFO tail, a_ack<=1, -> HOLD; when req_s=1 and count=DEPTH: stay IDLE, no write, a_ack stays 0 (backpressure).
REQ-017 HOLD: a_ack=1; when req_s=0 -> a_ack<=0, -> IDLE; else stay.
REQ-018 Exactly one FIFO write per 4-phase handshake; a_req held high SHALL never cause a second write.
REQ-019 Latency: a_ack and out_valid rise at the same edge the write occurs; write occurs SYNC_STAGES edges after a_req rise at earliest.
REQ-020 Pop: out_valid=1 and out_ready=1 at an edge removes head; out_valid = (count!=0).
REQ-021 Push and pop in same edge: count unchanged, both performed; full test for push uses count before the edge (pop at full SHALL NOT enable push that edge).
REQ-022 Pointers wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow; out_ready with count=0 has no effect.
REQ-023 out_data SHALL be the oldest unpopped word; value with out_valid=0 is don't-care.

Reset
REQ-024 rst=1 SHALL immediately force: a_ack=0, count=0, out_valid=0, pointers=0, synchronizer flops=0, state=RESYNC.
REQ-025 rst asserted mid-handshake (HOLD) SHALL drop a_ack asynchronously; pending FIFO contents are discarded.
REQ-026 After rst release a request still high SHALL NOT be captured; capture resumes only after req_s observed 0 (RESYNC).

Verification
REQ-027 Single token: reset, a_data=0xA5, raise a_req, out_ready=0 -> a_ack=1 and out_valid=1, out_data=0xA5, count=1 after 2 edges; drop a_req -> a_ack=0 after 2 edges; no second write.
REQ-028 Fill/backpressure: out_ready=0, send 5 tokens 0x01..0x05 with DEPTH=4 -> first 4 acked, count=4, 5th a_req held with a_ack=0; one pop -> 5th acked, count=4, order 0x02..0x05.
REQ-029 Simultaneous push/pop: count=2, out_ready=1 on the write edge -> count stays 2, head advances, data order preserved.
REQ-030 Wrap: stream 12 tokens 0x10..0x1B with out_ready toggling every edge -> output sequence exactly 0x10..0x1B, count never >4.
REQ-031 Reset mid-operation: assert rst in HOLD with count=3 -> a_ack=0, count=0 without clock edge; release with a_req=1 -> no write until a_req low then high again, then one write.
REQ-032 Empty pop: count=0, out_ready=1 for 5 edges -> count=0, out_valid=0 throughout.
